program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Byte-stream to instruction-memory writer: assembles bytes (from UART RX) into 32-bit words
//  and drives the fetch stage's preload port (i_preload_flag/_address/_instruction).
//  Sits between the debug UART receiver and seg_instruction_fetch; releases the pipeline
//  (o_load_done) once the program, terminated by HALT_WORD, is in program memory.
// PARAMETERS
//  LEN                32            preload address / instruction width
//  RAM_DEPTH_PROGRAM  32            program memory depth in words; last address = depth-1
//  HALT_WORD          32'hFFFFFFFF  end-of-program word; written to memory, then load ends
// PORTS
//  i_clk               in   1    clock
//  i_rst               in   1    synchronous active-high reset
//  i_start             in   1    1-cycle pulse: begin a load (honoured in IDLE/DONE only)
//  i_rx_data           in   8    received byte
//  i_rx_valid          in   1    1-cycle strobe, i_rx_data valid
//  o_preload_flag      out  1    to fetch i_preload_flag; memory writes while high
//  o_preload_address   out  LEN  to fetch i_preload_address (word address)
//  o_preload_instruction out LEN to fetch i_preload_instruction
//  o_busy              out  1    high in RECV/FLUSH
//  o_load_done         out  1    level, high in DONE
//  o_overflow          out  1    sticky: memory filled before HALT_WORD
//  o_checksum_err      out  1    sticky checksum mismatch (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; byte index 0; word counter 0.
//  FSM: IDLE -i_start-> RECV; RECV -last word-> FLUSH (-> CHECK if checksum) -> DONE;
//   DONE -i_start-> RECV (clears done/overflow/checksum_err, word counter 0, flag 0).
//  RECV: bytes big-endian, 1st byte -> [31:24] ... 4th -> [7:0]; i_rx_valid outside RECV/CHECK ignored.
//  4th byte accepted at edge N: o_preload_instruction = word, o_preload_address = word counter,
//   o_preload_flag = 1, all visible after edge N; counter +1. No write strobe: flag stays high
//   from first complete word to end of FLUSH; between words address/instruction hold the last
//   complete word (re-writes idempotent). Partial words never appear on the outputs.
//  Last word = HALT_WORD or address RAM_DEPTH_PROGRAM-1 (latter without halt sets o_overflow).
//  FLUSH: exactly 1 cycle, flag still high so memory captures the last word; then flag 0.
//  Bytes arriving in FLUSH/DONE ignored; i_start while busy ignored.
//  i_start and i_rx_valid same cycle in IDLE: start honoured, byte dropped.
//  Reset mid-load: immediate return to reset values; partial word discarded, flag 0 next cycle.
//  Address width: counter LEN bits, compare against RAM_DEPTH_PROGRAM-1, never wraps.
// CONFIGURATION
//  PROGRAM_LOADER_CHECKSUM_EN defined: XOR of all program bytes accumulated; after FLUSH
//   state CHECK waits for one extra byte; mismatch -> o_checksum_err=1; then DONE.
//   Overflow path skips CHECK.
//  Not defined: no CHECK state, no checksum byte, o_checksum_err tied 0.
// TESTING
//  1 i_start, bytes AB 8B 00 00, AB 8B 00 01, FF FF FF FF -> writes 0:AB8B0000, 1:AB8B0001,
//    2:FFFFFFFF; flag high from 1st word through FLUSH; o_load_done=1 after; fetch reads back.
//  2 4th byte at edge N -> address/instruction/flag updated after N; nothing before 4th byte.
//  3 RAM_DEPTH_PROGRAM=4, 4 non-halt words -> address 3 last, o_overflow=1, done, 5th word ignored.
//  4 i_rst after 2 bytes of word 1 -> all outputs 0; new i_start + 4 bytes -> writes address 0.
//  5 In DONE, bytes without i_start -> no flag; i_start during RECV -> ignored, counter unchanged.
//  6 CHECKSUM_EN: program 01 02 03 04 + HALT, check byte 04 -> err 0; byte 05 -> err 1.

Source files
------------

// File: rtl/program_loader.sv
// program_loader
//   Turns the debug UART byte stream into instruction-memory writes.
//   Every 4 bytes (big-endian, first byte -> [31:24]) make one word. The word
//   goes to the fetch stage's preload port at the next free word address.
//   Loading stops on HALT_WORD, which is itself written, or when the last
//   memory address has been written; the latter sets o_overflow.
//   The preload flag stays high from the first complete word through a
//   one-cycle FLUSH. This lets the memory capture the final word. After that
//   the pipeline is released through o_load_done.
//
// Optional feature (macro PROGRAM_LOADER_CHECKSUM_EN):
//   All program bytes, including the HALT_WORD bytes, are XORed together.
//   After FLUSH the CHECK state waits for one extra byte and compares it with
//   that XOR; a difference sets o_checksum_err. The overflow path goes
//   straight to DONE. When the macro is undefined there is no CHECK state and
//   o_checksum_err is tied to 0.
//
// Ports
//   i_clk, i_rst                clock, synchronous active-high reset
//   i_start                     1-cycle pulse; starts a load from IDLE or DONE
//   i_rx_data / i_rx_valid      received byte and its 1-cycle strobe
//   o_preload_flag              memory write enable toward fetch (level)
//   o_preload_address           word address of the current word
//   o_preload_instruction       current complete word
//   o_busy                      high while receiving or flushing
//   o_load_done                 high in DONE
//   o_overflow                  sticky: memory filled before HALT_WORD
//   o_checksum_err              sticky: checksum byte mismatch
module program_loader #(
    parameter int unsigned     LEN               = 32,
    parameter int unsigned     RAM_DEPTH_PROGRAM = 32,
    parameter logic [LEN-1:0]  HALT_WORD         = {LEN{1'b1}}
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic [7:0]     i_rx_data,
    input  logic           i_rx_valid,
    output logic           o_preload_flag,
    output logic [LEN-1:0] o_preload_address,
    output logic [LEN-1:0] o_preload_instruction,
    output logic           o_busy,
    output logic           o_load_done,
    output logic           o_overflow,
    output logic           o_checksum_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK = 3'd3;
`endif
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [LEN-1:0] LAST_ADDR = LEN'(RAM_DEPTH_PROGRAM - 1);

    logic [2:0]     state;
    logic [1:0]     byte_idx;
    logic [23:0]    byte_buf;
    logic [LEN-1:0] word_cnt;
    logic [31:0]    word_full;
    logic           word_is_halt;
    logic           at_last_addr;
    logic           byte_take;

    // The word is complete when the 4th byte is on i_rx_data; the first three
    // bytes are held in byte_buf.
    assign word_full    = {byte_buf, i_rx_data};
    assign word_is_halt = (LEN'(word_full) == HALT_WORD);
    assign at_last_addr = (word_cnt == LAST_ADDR);
    assign byte_take    = (state == S_RECV) && i_rx_valid;

    assign o_busy      = (state == S_RECV) || (state == S_FLUSH);
    assign o_load_done = (state == S_DONE);

    // Byte shift register. It needs no reset because byte_idx decides which
    // of its bytes are meaningful.
    always_ff @(posedge i_clk) begin
        if (byte_take && (byte_idx != 2'd3)) begin
            byte_buf <= {byte_buf[15:0], i_rx_data};
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] cs_acc;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                 <= S_IDLE;
            byte_idx              <= 2'd0;
            word_cnt              <= '0;
            o_preload_flag        <= 1'b0;
            o_preload_address     <= '0;
            o_preload_instruction <= '0;
            o_overflow            <= 1'b0;
            o_checksum_err        <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            cs_acc                <= 8'd0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // A byte that arrives with the start pulse is dropped,
                    // because byte_take is only true in RECV.
                    if (i_start) begin
                        state          <= S_RECV;
                        byte_idx       <= 2'd0;
                        word_cnt       <= '0;
                        o_preload_flag <= 1'b0;
                        o_overflow     <= 1'b0;
                        o_checksum_err <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        cs_acc         <= 8'd0;
`endif
                    end
                end
                S_RECV: begin
                    if (i_rx_valid) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        cs_acc <= cs_acc ^ i_rx_data;
`endif
                        if (byte_idx != 2'd3) begin
                            byte_idx <= byte_idx + 2'd1;
                        end else begin
                            // Only complete words reach the outputs. The
                            // outputs keep this word until the next one is
                            // complete, so repeated writes are harmless.
                            byte_idx              <= 2'd0;
                            o_preload_instruction <= LEN'(word_full);
                            o_preload_address     <= word_cnt;
                            o_preload_flag        <= 1'b1;
                            word_cnt              <= word_cnt + 1'b1;
                            if (word_is_halt) begin
                                state <= S_FLUSH;
                            end else if (at_last_addr) begin
                                state      <= S_FLUSH;
                                o_overflow <= 1'b1;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    // The flag stayed high for this cycle so the memory
                    // captures the last word; drop it now.
                    o_preload_flag <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    state <= o_overflow ? S_DONE : S_CHECK;
`else
                    state <= S_DONE;
`endif
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (i_rx_valid) begin
                        o_checksum_err <= (i_rx_data != cs_acc);
                        state          <= S_DONE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
module tb_program_loader;
  localparam int          DEPTH = 4;
  localparam logic [31:0] HALT  = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst, start, rx_valid;
  logic [7:0]  rx_data;
  logic        flag, busy, done, ovf, cs_err;
  logic [31:0] addr, instr;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog[$];
  logic [31:0] mem[DEPTH];
  logic        mem_clr = 1'b0;

  always #5 clk = ~clk;

  program_loader #(
    .LEN(32),
    .RAM_DEPTH_PROGRAM(DEPTH),
    .HALT_WORD(HALT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .o_preload_flag(flag),
    .o_preload_address(addr),
    .o_preload_instruction(instr),
    .o_busy(busy),
    .o_load_done(done),
    .o_overflow(ovf),
    .o_checksum_err(cs_err)
  );

  // Stand-in for the fetch stage's program memory: it writes whenever the
  // preload flag is high at a clock edge.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0BAD0BAD;
    end else if (flag && addr < DEPTH) begin
      mem[addr[1:0]] <= instr;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  // Model: the program ends at the first HALT or at the DEPTH-th word. The
  // words appear on the port in order, at addresses 0, 1, 2, and the memory
  // must afterwards hold exactly them.
  task automatic run_load(input int gap_max, input bit with_byte, input bit bad_cs);
    int          n;
    bit          ovf_exp;
    logic        exp_err;
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [31:0] w;
    n = prog.size();
    foreach (prog[i]) if (prog[i] == HALT && i < n) n = i + 1;
    if (n > DEPTH) n = DEPTH;
    ovf_exp = (prog[n-1] != HALT);
    exp_err = 1'b0;
    cs = 8'd0;

    mem_clr = 1'b1;
    tick();
    mem_clr = 1'b0;
    start = 1'b1;
    if (with_byte) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
    end
    tick();
    start = 1'b0;
    rx_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || flag !== 1'b0 || ovf !== 1'b0 || cs_err !== 1'b0) begin
      errors++;
      $display("FAIL start_state got busy=%b done=%b flag=%b ovf=%b err=%b expected 1 0 0 0 0", busy, done, flag, ovf, cs_err);
    end

    for (int i = 0; i < n; i++) begin
      w = prog[i];
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(gap_max, 0)) tick();
        b = w[31-8*k -: 8];
        cs ^= b;
        send_byte(b);
        if (k < 3) begin
          checks++;
          if (flag !== (i > 0)) begin
            errors++;
            $display("FAIL partial_flag word %0d byte %0d got %b expected %b", i, k, flag, (i > 0));
          end
          if (i > 0) begin
            checks++;
            if (addr !== 32'(i - 1) || instr !== prog[i-1]) begin
              errors++;
              $display("FAIL partial_hold got %h:%h expected %h:%h", addr, instr, 32'(i - 1), prog[i-1]);
            end
          end
        end else begin
          checks++;
          if (flag !== 1'b1 || addr !== 32'(i) || instr !== w) begin
            errors++;
            $display("FAIL word_out got flag=%b %h:%h expected flag=1 %h:%h", flag, addr, instr, 32'(i), w);
          end
        end
      end
    end

    checks++;
    if (busy !== 1'b1 || flag !== 1'b1) begin
      errors++;
      $display("FAIL flush got busy=%b flag=%b expected 1 1", busy, flag);
    end
    tick();
    checks++;
    if (flag !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_flush got flag=%b busy=%b expected 0 0", flag, busy);
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (!ovf_exp) begin
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL check_wait got done=%b expected 0", done);
      end
      repeat ($urandom_range(gap_max, 0)) tick();
      send_byte(bad_cs ? (cs ^ 8'h01) : cs);
      exp_err = bad_cs;
    end
`endif
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done got %b expected 1", done);
    end
    checks++;
    if (ovf !== ovf_exp) begin
      errors++;
      $display("FAIL overflow got %b expected %b", ovf, ovf_exp);
    end
    checks++;
    if (cs_err !== exp_err) begin
      errors++;
      $display("FAIL checksum_err got %b expected %b (cs %h)", cs_err, exp_err, cs);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (mem[i] !== prog[i]) begin
        errors++;
        $display("FAIL mem[%0d] got %h expected %h", i, mem[i], prog[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (3) tick();
    checks++;
    if (flag !== 1'b0 || addr !== 32'd0 || instr !== 32'd0) begin
      errors++;
      $display("FAIL reset_port got flag=%b %h:%h expected 0 0:0", flag, addr, instr);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0 || cs_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_status got %b%b%b%b expected 0000", busy, done, ovf, cs_err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    prog = '{32'hAB8B0000, 32'hAB8B0001, HALT};
    run_load(0, 1'b1, 1'b0);
  endtask

  task automatic test_random_programs();
    for (int it = 0; it < 8; it++) begin
      prog = '{};
      if ($urandom_range(3, 0) == 0) begin
        for (int j = 0; j < DEPTH; j++) prog.push_back(rand_word());
      end else begin
        for (int j = 0; j < int'($urandom_range(DEPTH - 1, 0)); j++) prog.push_back(rand_word());
        prog.push_back(HALT);
      end
      run_load(3, 1'($urandom_range(1, 0)), 1'b0);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] extra;
    prog = '{};
    for (int j = 0; j < DEPTH; j++) prog.push_back(rand_word());
    extra = rand_word();
    run_load(1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(extra[31-8*k -: 8]);
    tick();
    checks++;
    if (flag !== 1'b0 || addr !== 32'(DEPTH - 1) || instr !== prog[DEPTH-1] || done !== 1'b1) begin
      errors++;
      $display("FAIL overflow_ignore got flag=%b %h:%h done=%b expected 0 %h:%h 1", flag, addr, instr, done, 32'(DEPTH - 1), prog[DEPTH-1]);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] w;
    w = rand_word();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
    send_byte(8'h12);
    send_byte(8'h34);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (flag !== 1'b0 || addr !== 32'd0 || instr !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got flag=%b %h:%h busy=%b done=%b expected 0 0:0 0 0", flag, addr, instr, busy, done);
    end
    prog = '{32'h12345678, HALT};
    run_load(0, 1'b1, 1'b0);
  endtask

  task automatic test_done_ignore();
    logic [31:0] w;
    logic [7:0]  cs;
    for (int k = 0; k < 4; k++) send_byte(8'($urandom));
    checks++;
    if (flag !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL done_bytes got flag=%b done=%b expected 0 1", flag, done);
    end
    w = rand_word();
    cs = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    start = 1'b1; tick(); start = 1'b0;
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    start = 1'b1; tick(); start = 1'b0;
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    checks++;
    if (flag !== 1'b1 || addr !== 32'd0 || instr !== w || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_in_recv got flag=%b %h:%h busy=%b expected 1 0:%h 1", flag, addr, instr, busy, w);
    end
    for (int k = 0; k < 4; k++) send_byte(8'hFF);
    checks++;
    if (addr !== 32'd1 || instr !== HALT) begin
      errors++;
      $display("FAIL recv_halt got %h:%h expected 1:%h", addr, instr, HALT);
    end
    tick();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(cs);
`endif
    checks++;
    if (done !== 1'b1 || cs_err !== 1'b0) begin
      errors++;
      $display("FAIL recv_done got done=%b err=%b expected 1 0 (cs %h)", done, cs_err, cs);
    end
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    prog = '{32'h01020304, HALT};
    run_load(1, 1'b0, 1'b0);
    run_load(1, 1'b0, 1'b1);
    run_load(0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_load();
    test_directed();
    test_random_programs();
    test_overflow();
    test_done_ignore();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
